// File: rtl/fir_result_collector.sv
// Result collector for the FIR accelerator: buffers valid MAC results in a FWFT FIFO,
// drains them over valid/ready, and tracks overflow, dropped words and peak magnitude.
module fir_result_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int DROP_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [DATA_WIDTH-1:0]   macResult,
    input  logic                           resultIsValid,
    input  logic                           clearStats,
    output logic signed [DATA_WIDTH-1:0]   outData,
    output logic                           outValid,
    input  logic                           outReady,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic                           overflow,
    output logic [DROP_WIDTH-1:0]          dropCount,
    output logic [DATA_WIDTH-1:0]          peakMag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    localparam logic signed [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic        [DATA_WIDTH-1:0] MAX_POS  = {1'b0, {(DATA_WIDTH-1){1'b1}}};

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_WIDTH-1:0] dropCount_q, dropCount_d;
    logic [DATA_WIDTH-1:0] peakMag_q, peakMag_d;

    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [DATA_WIDTH-1:0] resultMag;

    // A pop frees the slot in the same cycle, so a full FIFO can still accept a push.
    always_comb begin
        full = (level_q == LVL_W'(DEPTH));
        pop  = outValid & outReady;
        push = resultIsValid & (~full | pop);
        drop = resultIsValid & full & ~pop;
    end

    // Magnitude saturates so the most-negative input still fits in DATA_WIDTH bits.
    always_comb begin
        if (macResult == MOST_NEG) begin
            resultMag = MAX_POS;
        end else if (macResult[DATA_WIDTH-1]) begin
            resultMag = DATA_WIDTH'(-macResult);
        end else begin
            resultMag = DATA_WIDTH'(macResult);
        end
    end

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        level_d = level_q;

        if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    // Clear is applied first so a same-cycle drop or push still lands in the statistics.
    always_comb begin
        overflow_d  = clearStats ? 1'b0 : overflow_q;
        dropCount_d = clearStats ? '0   : dropCount_q;
        peakMag_d   = clearStats ? '0   : peakMag_q;

        if (drop) begin
            overflow_d = 1'b1;
            if (dropCount_d != {DROP_WIDTH{1'b1}}) begin
                dropCount_d = dropCount_d + DROP_WIDTH'(1);
            end
        end
        if (push && (resultMag > peakMag_d)) begin
            peakMag_d = resultMag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            dropCount_q <= '0;
            peakMag_q   <= '0;
        end else begin
            wrPtr_q     <= wrPtr_d;
            rdPtr_q     <= rdPtr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            dropCount_q <= dropCount_d;
            peakMag_q   <= peakMag_d;
        end
    end

    // Storage needs no reset: an entry is only visible once level covers it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= macResult;
        end
    end

    always_comb begin
        outValid  = (level_q != '0);
        outData   = outValid ? mem_q[rdPtr_q] : '0;
        level     = level_q;
        overflow  = overflow_q;
        dropCount = dropCount_q;
        peakMag   = peakMag_q;
    end

endmodule
